// File: rtl/div_if.sv
// Handshake and data bundle between the EX datapath and the iterative divider.
interface div_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  flush;
  logic                  start;
  logic [5:0]            funct;
  logic [DATA_WIDTH-1:0] operand_1;
  logic [DATA_WIDTH-1:0] operand_2;
  logic                  stall_request;
  logic                  done;
  logic [DATA_WIDTH-1:0] result_lo;
  logic [DATA_WIDTH-1:0] result_hi;

  // EX datapath side: issues operations and consumes results.
  modport master (
    output flush, start, funct, operand_1, operand_2,
    input  stall_request, done, result_lo, result_hi
  );

  // Divider side.
  modport slave (
    input  flush, start, funct, operand_1, operand_2,
    output stall_request, done, result_lo, result_hi
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Quotient goes to result_lo, remainder to result_hi; the pipeline is held
// through stall_request until the single-cycle done pulse.
module div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ITER_CNT_W = 6
) (
  input logic   clk,
  input logic   rst_n,
  div_if.slave  bus
);

  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU = 6'h1B;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ITER_CNT_W-1:0] LAST_STEP = ITER_CNT_W'(DATA_WIDTH - 1);

  logic [1:0]            state;
  logic [ITER_CNT_W-1:0] counter;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] divisor_q;
  logic                  neg_quo_q;
  logic                  neg_rem_q;
  logic [DATA_WIDTH-1:0] result_lo_q;
  logic [DATA_WIDTH-1:0] result_hi_q;

  logic                  is_div_op;
  logic                  start_ok;
  logic                  op_signed;
  logic [DATA_WIDTH-1:0] mag_1;
  logic [DATA_WIDTH-1:0] mag_2;

  logic [DATA_WIDTH:0]   partial;
  logic [DATA_WIDTH-1:0] diff;
  logic                  ge;
  logic [DATA_WIDTH-1:0] rem_step;
  logic [DATA_WIDTH-1:0] quo_step;
  logic [DATA_WIDTH-1:0] quo_fix;
  logic [DATA_WIDTH-1:0] rem_fix;

  // Decode the incoming request and form operand magnitudes for signed DIV.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    is_div_op = 1'b0;
    op_signed = 1'b0;
    mag_1     = bus.operand_1;
    mag_2     = bus.operand_2;
    if (bus.funct == FUNCT_DIV || bus.funct == FUNCT_DIVU) is_div_op = 1'b1;
    if (bus.funct == FUNCT_DIV) op_signed = 1'b1;
    if (op_signed && bus.operand_1[DATA_WIDTH-1]) mag_1 = -bus.operand_1;
    if (op_signed && bus.operand_2[DATA_WIDTH-1]) mag_2 = -bus.operand_2;
  end

  assign start_ok = bus.start && is_div_op;

  // One restoring step: shift {rem,quo} left, trial-subtract, keep if non-negative.
  // While rem < divisor holds, partial < 2*divisor, so the difference fits DATA_WIDTH bits.
  always_comb begin
    partial  = {rem_q, quo_q[DATA_WIDTH-1]};
    ge       = (partial >= {1'b0, divisor_q});
    diff     = partial[DATA_WIDTH-1:0] - divisor_q;
    rem_step = ge ? diff : partial[DATA_WIDTH-1:0];
    quo_step = {quo_q[DATA_WIDTH-2:0], ge};
    quo_fix  = neg_quo_q ? -quo_step : quo_step;
    rem_fix  = neg_rem_q ? -rem_step : rem_step;
  end

  // Stall holds the pipeline on issue and during iteration; flush and reset mask it at once.
  always_comb begin
    bus.stall_request = rst_n && !bus.flush &&
                        (((state == S_IDLE) && start_ok) || (state == S_RUN));
    bus.done          = (state == S_DONE) && !bus.flush;
  end

  assign bus.result_lo = result_lo_q;
  assign bus.result_hi = result_hi_q;

  // Control FSM, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state       <= S_IDLE;
      counter     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      result_lo_q <= '0;
      result_hi_q <= '0;
    end else if (bus.flush) begin
      state   <= S_IDLE;
      counter <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            rem_q     <= '0;
            quo_q     <= mag_1;
            divisor_q <= mag_2;
            neg_quo_q <= op_signed && (bus.operand_1[DATA_WIDTH-1] ^ bus.operand_2[DATA_WIDTH-1]);
            neg_rem_q <= op_signed && bus.operand_1[DATA_WIDTH-1];
            counter   <= '0;
            if (bus.operand_2 == '0) begin
              // Divide by zero finishes immediately with all-ones quotient and raw dividend.
              result_lo_q <= '1;
              result_hi_q <= bus.operand_1;
              state       <= S_DONE;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          rem_q   <= rem_step;
          quo_q   <= quo_step;
          counter <= counter + 1'b1;
          if (counter == LAST_STEP) begin
            result_lo_q <= quo_fix;
            result_hi_q <= rem_fix;
            state       <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random
// DIV/DIVU operations against a plain-arithmetic reference model.
module tb_div_unit;

  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU = 6'h1B;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;

  logic clk;
  logic rst_n;
  div_if bus ();

  div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit arithmetic gives truncating division with the remainder
  // taking the dividend's sign, and absorbs the -2^31 / -1 overflow case.
  function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  // Issue one divide at the next falling edge and follow it to done.
  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp_lo, exp_hi;
    int stalls;
    bit seen;
    ref_div(sgn, a, b, exp_lo, exp_hi);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.funct     = sgn ? FUNCT_DIV : FUNCT_DIVU;
    bus.operand_1 = a;
    bus.operand_2 = b;
    #1;
    check({tag, "_issue_done"}, 32'(bus.done), 32'd0);
    stalls = 0;
    seen   = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.stall_request) stalls++;
      @(negedge clk);
      // Operands are scrambled after issue; the divider must have latched them.
      bus.start     = 1'b0;
      bus.operand_1 = $urandom();
      bus.operand_2 = $urandom();
      #1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_stalls"}, 32'(stalls), (b == 32'd0) ? 32'd1 : 32'd33);
    check({tag, "_lo"}, bus.result_lo, exp_lo);
    check({tag, "_hi"}, bus.result_hi, exp_hi);
    check({tag, "_stall_in_done"}, 32'(bus.stall_request), 32'd0);
    last_lo = exp_lo;
    last_hi = exp_hi;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.start     = 1'b0;
    bus.funct     = '0;
    bus.operand_1 = '0;
    bus.operand_2 = '0;

    // Reset state.
    #12;
    check("rst_stall", 32'(bus.stall_request), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_lo", bus.result_lo, 32'd0);
    check("rst_hi", bus.result_hi, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the test plan.
    do_div(1'b0, 32'd100, 32'd7, "divu_100_7");
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    do_div(1'b0, 32'h0000_1234, 32'd0, "divu_by_zero");
    do_div(1'b1, 32'hFFFF_FF00, 32'd0, "div_by_zero");

    // Flush at RUN step 10 of 100 / 7.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.funct     = FUNCT_DIVU;
    bus.operand_1 = 32'd100;
    bus.operand_2 = 32'd7;
    repeat (11) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    #1;
    check("flush_stall", 32'(bus.stall_request), 32'd0);
    check("flush_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush_idle_stall", 32'(bus.stall_request), 32'd0);
    begin
      int done_seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        #1;
        if (bus.done) done_seen++;
      end
      check("flush_no_done", 32'(done_seen), 32'd0);
    end
    check("flush_lo_kept", bus.result_lo, last_lo);
    check("flush_hi_kept", bus.result_hi, last_hi);
    do_div(1'b0, 32'd9, 32'd3, "after_flush");

    // Non-divide funct with start is ignored.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.funct     = FUNCT_ADDU;
    bus.operand_1 = 32'd55;
    bus.operand_2 = 32'd5;
    #1;
    check("addu_stall", 32'(bus.stall_request), 32'd0);
    begin
      int done_seen = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        #1;
        if (bus.done) done_seen++;
      end
      check("addu_no_done", 32'(done_seen), 32'd0);
    end
    bus.start = 1'b0;
    check("addu_lo_kept", bus.result_lo, last_lo);
    check("addu_hi_kept", bus.result_hi, last_hi);

    // Random signed/unsigned operations, issued back-to-back.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      a = $urandom();
      case (i % 4)
        0: b = $urandom();
        1: b = 32'($urandom_range(1, 20));
        2: b = -32'($urandom_range(1, 20));
        default: b = (i == 23) ? 32'd0 : {16'h0, 16'($urandom())};
      endcase
      do_div(i[0], a, b, $sformatf("rand%0d", i));
    end

    // Reset pulled mid-RUN clears outputs at once.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.funct     = FUNCT_DIVU;
    bus.operand_1 = 32'd1000;
    bus.operand_2 = 32'd3;
    repeat (6) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_stall", 32'(bus.stall_request), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_lo", bus.result_lo, 32'd0);
    check("midrst_hi", bus.result_hi, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit radix-2 divider in the EX stage. It executes the DIV/DIVU operations whose FUNCT code the ID stage's funct generator forwards through ID/EX.
- Takes operands and funct from the EX datapath and holds the pipeline via a stall request while iterating.
- Returns quotient (LO) and remainder (HI) for the HI/LO write in the same cycle the stall drops.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- ITER_CNT_W, 6, width of the iteration counter; must hold the value DATA_WIDTH.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  pipeline flush (exception/eret); aborts any operation.
- start  input  1  EX holds a divide instruction this cycle.
- funct  input  6  FUNCT code from ID/EX; only FUNCT_DIV (0x1A) and FUNCT_DIVU (0x1B) are acted on.
- operand_1  input  32  dividend (rs).
- operand_2  input  32  divisor (rt).
- stall_request  output  1  holds IF/ID/EX while the divide is pending.
- done  output  1  one-cycle pulse; results are valid this cycle.
- result_lo  output  32  quotient.
- result_hi  output  32  remainder.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, done=0.
  - result_lo=0, result_hi=0, internal remainder/quotient regs=0.
  - stall_request=0 immediately.
- States: IDLE, RUN, DONE.
- IDLE:
  - A start is one where start=1 and funct is DIV or DIVU; all other start/funct combinations are ignored.
  - On a start, at the edge (call it E0), latch operands, sign flags and the signed flag.
  - Divisor!=0 -> go to RUN with counter=0. Divisor==0 -> go to DONE.
- RUN:
  - One restoring-division step per edge on the magnitudes.
  - Shift {rem,quo} left 1 and trial-subtract the divisor; if non-negative, keep the difference and set quo[0]=1.
  - counter increments each edge. On the 32nd step (edge E32) go to DONE and write the corrected results into result_lo/result_hi.
- DONE:
  - done=1 for exactly one cycle, then IDLE at the next edge.
  - Results hold their value until the next completion or reset.
- stall_request is combinational:
  - 1 when (state==IDLE and a start is present) or state==RUN.
  - 0 in DONE, so EX advances and consumes the results in the done cycle.
- Latency: done is high in the cycle after E32, i.e. 33 cycles of stall including the issue cycle. Divide-by-zero: done is high in the cycle after E0, i.e. 1 stall cycle.
- Signed (DIV):
  - Operate on |operand_1| and |operand_2|.
  - Quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- Unsigned (DIVU): raw operands, no correction.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This is the natural wrap from the algorithm and needs no special case.
- Divide by zero (both DIV and DIVU): lo=0xFFFFFFFF, hi=operand_1 unmodified.
- Flush:
  - Takes priority over everything in every state; next edge -> IDLE, counter=0.
  - No done pulse; result_lo/hi are left unchanged.
  - stall_request drops in the same cycle flush is asserted, combinationally masked.
- start during RUN/DONE is ignored; operand changes during RUN have no effect because operands are latched at E0.
- start asserted in the cycle immediately after DONE begins a new operation normally (back-to-back divides).

Test Plan:
- DIVU 100 / 7 -> stall_request=1 for 33 cycles; done pulse in the cycle after E32; lo=14, hi=2.
- DIV -7 (0xFFFFFFF9) / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 7 / -2 -> lo=-3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 0xFFFFFFFF / 1 -> lo=0xFFFFFFFF, hi=0.
- Divide by zero, DIVU 0x1234 / 0 -> done in the cycle after E0, lo=0xFFFFFFFF, hi=0x1234, one stall cycle.
- Flush at RUN step 10 of 100 / 7 -> no done, stall_request=0 in the flush cycle, state IDLE. A following DIVU 9 / 3 then yields lo=3, hi=0 after the full 33-cycle latency.
- rst_n pulled low mid-RUN -> outputs are 0 immediately. Also: start with funct=FUNCT_ADDU -> no stall and no done; results unchanged.
